// File: rtl/uart_tx_frame_counter_if.sv
// Handshake/config/status bundle between the TX control FSM (master) and the
// combined baud-divider / frame bit counter (slave).
interface uart_tx_frame_counter_if #(
    parameter int DIV_WIDTH = 16,
    parameter int IDX_WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic [DIV_WIDTH-1:0] divisor;
    logic [1:0]           data_len;
    logic                 parity_en;
    logic                 stop2;

    logic                 busy;
    logic                 bit_tick;
    logic [IDX_WIDTH-1:0] bit_idx;
    logic [1:0]           phase;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output start, abort, divisor, data_len, parity_en, stop2,
        input  busy, bit_tick, bit_idx, phase, done, cfg_err
    );

    modport slave (
        input  start, abort, divisor, data_len, parity_en, stop2,
        output busy, bit_tick, bit_idx, phase, done, cfg_err
    );
endinterface

// File: rtl/uart_tx_frame_counter.sv
// UART TX frame counter: baud divider plus frame bit counter producing one
// strobe per bit period, the bit index/phase, and a done pulse per frame.
module uart_tx_frame_counter #(
    parameter int DIV_WIDTH = 16,
    parameter int IDX_WIDTH = 4
) (
    input logic                   clk,
    input logic                   reset,
    uart_tx_frame_counter_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_START  = 2'd0,
        PH_DATA   = 2'd1,
        PH_PARITY = 2'd2,
        PH_STOP   = 2'd3
    } phase_t;

    state_t               state;
    state_t               state_next;
    phase_t               phase;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [IDX_WIDTH-1:0] bit_idx;
    logic [1:0]           len_lat;
    logic                 par_lat;
    logic                 stop2_lat;
    logic                 done_r;
    logic                 cfg_err_r;

    logic                 tick;
    logic                 accept;
    logic                 cfg_bad;
    logic                 frame_end;
    logic                 abort_run;
    logic [IDX_WIDTH-1:0] data_last;
    logic [IDX_WIDTH-1:0] last_idx;

    // Everything below is decoded from registers so bit_tick is glitch-free
    // relative to the inputs.
    assign tick      = (state == RUN) && (div_cnt == '0);
    assign data_last = IDX_WIDTH'(5) + IDX_WIDTH'(len_lat);
    assign last_idx  = data_last + IDX_WIDTH'(par_lat) + IDX_WIDTH'(1) + IDX_WIDTH'(stop2_lat);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        cfg_bad    = 1'b0;
        frame_end  = 1'b0;
        abort_run  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort takes priority over a coinciding final tick.
                if (bus.abort) begin
                    abort_run  = 1'b1;
                    state_next = IDLE;
                end else if (tick && (bit_idx == last_idx)) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt   <= '0;
            div_lat   <= '0;
            bit_idx   <= '0;
            len_lat   <= '0;
            par_lat   <= 1'b0;
            stop2_lat <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            done_r    <= frame_end;
            cfg_err_r <= cfg_bad;
            if (accept) begin
                div_lat   <= bus.divisor;
                len_lat   <= bus.data_len;
                par_lat   <= bus.parity_en;
                stop2_lat <= bus.stop2;
                div_cnt   <= bus.divisor - DIV_WIDTH'(1);
                bit_idx   <= '0;
            end else if (abort_run || frame_end) begin
                div_cnt <= '0;
                bit_idx <= '0;
            end else if (tick) begin
                div_cnt <= div_lat - DIV_WIDTH'(1);
                bit_idx <= bit_idx + IDX_WIDTH'(1);
            end else if (state == RUN) begin
                div_cnt <= div_cnt - DIV_WIDTH'(1);
            end
        end
    end

    always_comb begin
        phase = PH_STOP;
        if ((state == IDLE) || (bit_idx == '0)) begin
            phase = PH_START;
        end else if (bit_idx <= data_last) begin
            phase = PH_DATA;
        end else if (par_lat && (bit_idx == data_last + IDX_WIDTH'(1))) begin
            phase = PH_PARITY;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.bit_tick = tick;
    assign bus.bit_idx  = bit_idx;
    assign bus.phase    = phase;
    assign bus.done     = done_r;
    assign bus.cfg_err  = cfg_err_r;
endmodule

// File: tb/tb_uart_tx_frame_counter.sv
// Self-checking bench for uart_tx_frame_counter: a per-frame scoreboard of
// expected bit ticks (index, phase, cycle) plus busy/done/cfg_err timing.
module tb_uart_tx_frame_counter;
    localparam int DW = 16;
    localparam int IW = 4;

    typedef struct {
        int idx;
        int ph;
        int at;
    } exp_tick_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    exp_tick_t sb[$];

    uart_tx_frame_counter_if #(.DIV_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    uart_tx_frame_counter #(.DIV_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Entered and left on a negedge. Drives start at entry; when the previous
    // frame ended on its done cycle this gives a back-to-back start.
    task automatic run_frame(input string tag, input int dv, input int len,
                             input bit par, input bit s2, input int poke_cyc);
        int        n;
        int        d;
        int        last;
        exp_tick_t e;
        n    = 1 + (5 + len) + int'(par) + 1 + int'(s2);
        d    = 5 + len;
        last = n * dv + 1;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            e.idx = i;
            e.ph  = (i == 0) ? 0 : (i <= d) ? 1 : (par && i == d + 1) ? 2 : 3;
            e.at  = (i + 1) * dv;
            sb.push_back(e);
        end
        bus.divisor   = DW'(dv);
        bus.data_len  = 2'(len);
        bus.parity_en = par;
        bus.stop2     = s2;
        bus.start     = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== (cyc < last)) begin
                n_fail++;
                $display("FAIL %s busy cyc %0d: got %b expected %b", tag, cyc, bus.busy, cyc < last);
            end
            n_checks++;
            if (bus.done !== (cyc == last)) begin
                n_fail++;
                $display("FAIL %s done cyc %0d: got %b expected %b", tag, cyc, bus.done, cyc == last);
            end
            n_checks++;
            if (bus.cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cfg_err cyc %0d: got %b expected 0", tag, cyc, bus.cfg_err);
            end
            if (cyc == 1) begin
                n_checks++;
                if (bus.bit_idx !== '0) begin
                    n_fail++;
                    $display("FAIL %s first bit_idx: got %0d expected 0", tag, bus.bit_idx);
                end
            end
            if (bus.bit_tick === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra bit_tick cyc %0d: got tick expected none", tag, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.bit_idx !== IW'(e.idx) || bus.phase !== 2'(e.ph) || cyc != e.at) begin
                        n_fail++;
                        $display("FAIL %s tick: got idx %0d phase %0d cyc %0d expected idx %0d phase %0d cyc %0d",
                                 tag, bus.bit_idx, bus.phase, cyc, e.idx, e.ph, e.at);
                    end
                end
            end
            // Config changes and a start with divisor 0 while busy must be ignored.
            bus.start = 1'b0;
            if (cyc == 2) begin
                bus.divisor   = DW'(dv + 5);
                bus.data_len  = ~bus.data_len;
                bus.parity_en = ~par;
                bus.stop2     = ~s2;
            end
            if (poke_cyc != 0 && cyc == poke_cyc) begin
                bus.start   = 1'b1;
                bus.divisor = '0;
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing ticks: got %0d left expected 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.bit_tick, bus.bit_idx, bus.phase, bus.done, bus.cfg_err} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got busy %b tick %b idx %0d phase %0d done %b err %b expected all 0",
                     bus.busy, bus.bit_tick, bus.bit_idx, bus.phase, bus.done, bus.cfg_err);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset idle: got busy %b done %b expected 0 0", bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_8n1();
        run_frame("8n1", 4, 3, 1'b0, 1'b0, 0);
        idle_cycles(2);
    endtask

    task automatic test_5e2();
        run_frame("5e2", 1, 0, 1'b1, 1'b1, 0);
        idle_cycles(2);
    endtask

    task automatic test_cfg_and_busy_start();
        bus.divisor = '0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err pulse: got err %b busy %b expected 1 0", bus.cfg_err, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err clear: got err %b busy %b expected 0 0", bus.cfg_err, bus.busy);
        end
        run_frame("busy_start", 2, 2, 1'b0, 1'b1, 7);
        idle_cycles(2);
    endtask

    task automatic wait_for(input string tag, input int idx, input bit need_tick, output bit hit);
        int k;
        hit = 1'b0;
        k   = 0;
        while (!hit && k < 200) begin
            if (bus.bit_idx == IW'(idx) && bus.busy && (!need_tick || bus.bit_tick)) hit = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s wait: got no bit_idx %0d within 200 cycles expected it", tag, idx);
        end
    endtask

    task automatic test_abort();
        bit hit;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort idle: got busy %b done %b expected 0 0", bus.busy, bus.done);
        end
        // Abort mid-frame at bit 3.
        bus.divisor = DW'(4); bus.data_len = 2'd3; bus.parity_en = 1'b0; bus.stop2 = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_for("abort_mid", 3, 1'b0, hit);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.bit_idx !== '0 || bus.done !== 1'b0 || bus.phase !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_mid: got busy %b idx %0d done %b phase %0d expected 0 0 0 0",
                     bus.busy, bus.bit_idx, bus.done, bus.phase);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mid late done: got %b expected 0", bus.done);
        end
        // Abort coinciding with the final tick of a 7-bit frame.
        bus.divisor = DW'(2); bus.data_len = 2'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_for("abort_last", 6, 1'b1, hit);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_last: got busy %b done %b expected 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_last late done: got %b expected 0", bus.done);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_and_back_to_back();
        bit hit;
        bus.divisor = DW'(2); bus.data_len = 2'd3; bus.parity_en = 1'b0; bus.stop2 = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_for("reset_mid", 5, 1'b0, hit);
        reset     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.bit_tick, bus.bit_idx, bus.phase, bus.done, bus.cfg_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got busy %b tick %b idx %0d phase %0d done %b err %b expected all 0",
                     bus.busy, bus.bit_tick, bus.bit_idx, bus.phase, bus.done, bus.cfg_err);
        end
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid release: got busy %b expected 0", bus.busy);
        end
        run_frame("b2b_first", 3, 3, 1'b0, 1'b0, 0);
        run_frame("b2b_second", 2, 1, 1'b1, 1'b0, 0);
        idle_cycles(2);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.divisor   = '0;
        bus.data_len  = '0;
        bus.parity_en = 1'b0;
        bus.stop2     = 1'b0;
        test_reset();
        test_8n1();
        test_5e2();
        test_cfg_and_busy_start();
        test_abort();
        test_reset_mid_and_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
